// File: rtl/lvds_rx_pkg.sv
// Shared encodings and defaults for the LVDS DDR receive framer.
package lvds_rx_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'b00,
      I_PH = 2'b01,
      Q_PH = 2'b11
   } rx_state_t;

   localparam logic [1:0]  DEF_I_SYNC      = 2'b10;
   localparam logic [1:0]  DEF_Q_SYNC      = 2'b01;
   localparam int unsigned DEF_SAMPLE_W    = 13;
   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_LOCK_FRAMES = 4;

   // Dibits per half-frame: sync dibit + sample + one pad bit.
   function automatic int unsigned half_dibits(input int unsigned sample_w);
      return (sample_w + 3) / 2;
   endfunction

endpackage

// File: rtl/lvds_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module lvds_sat_counter
   import lvds_rx_pkg::*;
#(
   parameter int unsigned W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lvds_rx_framer.sv
// Lock-qualified I/Q deserializer for the 2-bit DDR LVDS sample stream.
// Define LVDS_RX_FRAMER_STATS_EN to build the sync-error and overflow counters.
module lvds_rx_framer
   import lvds_rx_pkg::*;
#(
   parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
   parameter logic [1:0]  I_SYNC      = DEF_I_SYNC,
   parameter logic [1:0]  Q_SYNC      = DEF_Q_SYNC,
   parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic                      i_ddr_clk,
   input  logic                      i_rst_b,
   input  logic [1:0]                i_ddr_data,
   input  logic                      i_sync_input,
   input  logic                      i_cnt_clear,
   input  logic                      i_fifo_full,
   output logic                      o_fifo_write_clk,
   output logic                      o_fifo_push,
   output logic [2*(SAMPLE_W+3)-1:0] o_fifo_data,
   output logic                      o_locked,
   output logic [CNT_W-1:0]          o_sync_err_cnt,
   output logic [CNT_W-1:0]          o_ovf_cnt,
   output logic [1:0]                o_debug_state
);

   localparam int unsigned HALF = half_dibits(SAMPLE_W);
   localparam int unsigned DC_W = $clog2(HALF);
   localparam int unsigned GC_W = $clog2(LOCK_FRAMES + 1);

   localparam logic [DC_W-1:0] LAST_I   = DC_W'(HALF - 1);
   localparam logic [DC_W-1:0] LAST_DAT = DC_W'(HALF - 2);
   localparam logic [GC_W-1:0] LOCK_MAX = GC_W'(LOCK_FRAMES);

   rx_state_t           state;
   logic [DC_W-1:0]     dib_cnt;
   logic [GC_W-1:0]     good_cnt;
   logic [SAMPLE_W-1:0] i_smp;
   logic [SAMPLE_W-2:0] q_smp;
   logic                r_mark;
   logic                expect_q;

   logic sync_err_c;
   logic frame_done_c;
   logic lock_next_c;
   logic ovf_c;

   assign o_fifo_write_clk = i_ddr_clk;
   assign o_debug_state    = state;

   // Frame events decoded from the current state and incoming dibit.
   always_comb begin
      sync_err_c   = 1'b0;
      frame_done_c = 1'b0;
      case (state)
         HUNT:    sync_err_c   = expect_q && (i_ddr_data != I_SYNC);
         I_PH:    sync_err_c   = (dib_cnt == LAST_I) && (i_ddr_data != Q_SYNC);
         Q_PH:    frame_done_c = (dib_cnt == LAST_DAT);
         default: ;
      endcase
   end

   assign lock_next_c = o_locked || (good_cnt >= (LOCK_MAX - 1'b1));
   assign ovf_c       = frame_done_c && lock_next_c && i_fifo_full;

   always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         state       <= HUNT;
         dib_cnt     <= '0;
         good_cnt    <= '0;
         i_smp       <= '0;
         q_smp       <= '0;
         r_mark      <= 1'b0;
         expect_q    <= 1'b0;
         o_locked    <= 1'b0;
         o_fifo_push <= 1'b0;
         o_fifo_data <= '0;
      end else begin
         o_fifo_push <= 1'b0;
         if (sync_err_c) begin
            o_locked <= 1'b0;
            good_cnt <= '0;
         end
         case (state)
            HUNT: begin
               expect_q <= 1'b0;
               dib_cnt  <= '0;
               if (i_ddr_data == I_SYNC) begin
                  state  <= I_PH;
                  r_mark <= i_sync_input;
               end
            end
            I_PH: begin
               dib_cnt <= dib_cnt + 1'b1;
               if (dib_cnt == LAST_I) begin
                  dib_cnt <= '0;
                  state   <= (i_ddr_data == Q_SYNC) ? Q_PH : HUNT;
               end else if (dib_cnt == LAST_DAT) begin
                  // Last I dibit: keep the sample LSB, drop the wire pad bit.
                  i_smp <= {i_smp[SAMPLE_W-2:0], i_ddr_data[1]};
               end else begin
                  i_smp <= {i_smp[SAMPLE_W-3:0], i_ddr_data};
               end
            end
            Q_PH: begin
               dib_cnt <= dib_cnt + 1'b1;
               if (frame_done_c) begin
                  state    <= HUNT;
                  expect_q <= 1'b1;
                  dib_cnt  <= '0;
                  good_cnt <= (good_cnt == LOCK_MAX) ? good_cnt : good_cnt + 1'b1;
                  o_locked <= lock_next_c;
                  if (lock_next_c && !i_fifo_full) begin
                     o_fifo_push <= 1'b1;
                     o_fifo_data <= {I_SYNC, i_smp, r_mark, Q_SYNC, q_smp, i_ddr_data[1], 1'b0};
                  end
               end else begin
                  q_smp <= {q_smp[SAMPLE_W-4:0], i_ddr_data};
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   logic cnt_clr;
   logic err_inc;
   logic ovf_inc;

`ifdef LVDS_RX_FRAMER_STATS_EN
   assign cnt_clr = i_cnt_clear;
   assign err_inc = sync_err_c;
   assign ovf_inc = ovf_c;
`else
   logic unused_stats;
   assign unused_stats = i_cnt_clear | ovf_c;
   assign cnt_clr      = 1'b0;
   assign err_inc      = 1'b0;
   assign ovf_inc      = 1'b0;
`endif

   lvds_sat_counter #(.W(CNT_W)) u_sync_err_cnt (
      .clk   (i_ddr_clk),
      .rst_b (i_rst_b),
      .clr   (cnt_clr),
      .inc   (err_inc),
      .cnt   (o_sync_err_cnt)
   );

   lvds_sat_counter #(.W(CNT_W)) u_ovf_cnt (
      .clk   (i_ddr_clk),
      .rst_b (i_rst_b),
      .clr   (cnt_clr),
      .inc   (ovf_inc),
      .cnt   (o_ovf_cnt)
   );

endmodule

// File: tb/tb_lvds_rx_framer.sv
// Self-checking bench for lvds_rx_framer against a frame-level reference model.
module tb_lvds_rx_framer;

   localparam int unsigned SW   = 13;
   localparam int unsigned LF   = 4;
   localparam int unsigned CW   = 2;
   localparam int          CMAX = (1 << CW) - 1;
   localparam logic [1:0]  ISY  = 2'b10;
   localparam logic [1:0]  QSY  = 2'b01;
`ifdef LVDS_RX_FRAMER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          i_ddr_clk = 1'b0;
   logic          i_rst_b;
   logic [1:0]    i_ddr_data;
   logic          i_sync_input;
   logic          i_cnt_clear;
   logic          i_fifo_full;
   logic          o_fifo_write_clk;
   logic          o_fifo_push;
   logic [31:0]   o_fifo_data;
   logic          o_locked;
   logic [CW-1:0] o_sync_err_cnt;
   logic [CW-1:0] o_ovf_cnt;
   logic [1:0]    o_debug_state;

   always #5 i_ddr_clk = ~i_ddr_clk;

   lvds_rx_framer #(.SAMPLE_W(SW), .LOCK_FRAMES(LF), .CNT_W(CW)) dut (
      .i_ddr_clk        (i_ddr_clk),
      .i_rst_b          (i_rst_b),
      .i_ddr_data       (i_ddr_data),
      .i_sync_input     (i_sync_input),
      .i_cnt_clear      (i_cnt_clear),
      .i_fifo_full      (i_fifo_full),
      .o_fifo_write_clk (o_fifo_write_clk),
      .o_fifo_push      (o_fifo_push),
      .o_fifo_data      (o_fifo_data),
      .o_locked         (o_locked),
      .o_sync_err_cnt   (o_sync_err_cnt),
      .o_ovf_cnt        (o_ovf_cnt),
      .o_debug_state    (o_debug_state)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state, updated per frame / per idle dibit
   int          m_good;
   bit          m_locked;
   bit          m_expect;
   int          m_err;
   int          m_ovf;
   bit          m_push;
   int          m_pushes;
   logic [31:0] m_data;
   int          push_seen = 0;

   always @(negedge i_ddr_clk) if (o_fifo_push === 1'b1) push_seen++;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   function automatic logic [1:0] idle_dibit();
      logic [1:0] d;
      d = 2'($urandom_range(0, 2));
      return (d == ISY) ? 2'b11 : d;
   endfunction

   task automatic model_reset();
      m_good = 0; m_locked = 0; m_expect = 0; m_err = 0; m_ovf = 0;
      m_push = 0; m_data = '0;
   endtask

   task automatic tick(input logic [1:0] d, input logic full);
      i_ddr_data  = d;
      i_fifo_full = full;
      @(posedge i_ddr_clk);
      #1;
   endtask

   // Drives one frame; outputs are sampled right after the deciding edge.
   task automatic send_frame(input logic [12:0] iv, input logic [12:0] qv, input logic mark,
                             input logic [1:0] qsync, input logic full,
                             output logic push, output logic [31:0] data);
      logic [13:0] ib, qb;
      bit          lock_next;
      ib = {iv, 1'($urandom)};
      qb = {qv, 1'($urandom)};
      i_sync_input = mark;
      tick(ISY, 1'($urandom));
      m_expect = 0;
      i_sync_input = 1'($urandom);
      for (int k = 0; k < 7; k++) tick(ib[13-2*k -: 2], 1'($urandom));
      tick(qsync, 1'($urandom));
      if (qsync != QSY) begin
         if (STATS) m_err = sat(m_err);
         m_locked = 0; m_good = 0; m_push = 0;
         push = o_fifo_push; data = o_fifo_data;
         return;
      end
      for (int k = 0; k < 7; k++) tick(qb[13-2*k -: 2], (k == 6) ? full : 1'($urandom));
      push = o_fifo_push; data = o_fifo_data;
      m_good    = (m_good + 1 > LF) ? LF : m_good + 1;
      lock_next = m_locked || (m_good >= LF);
      m_push    = lock_next && !full;
      if (m_push) begin
         m_data = {ISY, iv, mark, QSY, qv, 1'b0};
         m_pushes++;
      end else if (lock_next && STATS) begin
         m_ovf = sat(m_ovf);
      end
      m_locked = lock_next;
      m_expect = 1;
   endtask

   task automatic send_idle(input logic [1:0] d, input logic clr);
      i_cnt_clear = clr;
      tick(d, 1'($urandom));
      i_cnt_clear = 1'b0;
      if (clr && STATS) begin
         m_err = 0; m_ovf = 0;
      end else if (m_expect && STATS) begin
         m_err = sat(m_err);
      end
      if (m_expect) begin
         m_locked = 0; m_good = 0;
      end
      m_expect = 0;
   endtask

   task automatic test_reset();
      i_rst_b = 1'b0; i_ddr_data = 2'b00; i_sync_input = 1'b0;
      i_cnt_clear = 1'b0; i_fifo_full = 1'b0;
      model_reset();
      m_pushes = 0;
      #12;
      checks++; if (o_fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push got %b want 0", o_fifo_push); end
      checks++; if (o_fifo_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", o_fifo_data); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", o_locked); end
      checks++; if (o_debug_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", o_debug_state); end
      checks++; if (o_sync_err_cnt !== 2'd0 || o_ovf_cnt !== 2'd0) begin
         errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", o_sync_err_cnt, o_ovf_cnt); end
      checks++; if (o_fifo_write_clk !== i_ddr_clk) begin errors++; $display("FAIL write_clk got %b want %b", o_fifo_write_clk, i_ddr_clk); end
      @(negedge i_ddr_clk); i_rst_b = 1'b1;
      @(posedge i_ddr_clk); #1;
   endtask

   task automatic test_lock_acq();
      logic push; logic [31:0] data;
      for (int f = 1; f <= 5; f++) begin
         send_frame(13'h0AAA, 13'h1555, 1'b1, QSY, 1'b0, push, data);
         checks++; if (push !== (f >= 4)) begin errors++; $display("FAIL lock_push frame %0d got %b want %b", f, push, f >= 4); end
         checks++; if (o_locked !== (f >= 4)) begin errors++; $display("FAIL lock_status frame %0d got %b want %b", f, o_locked, f >= 4); end
         checks++; if (o_debug_state !== 2'b00) begin errors++; $display("FAIL lock_state frame %0d got %b want 00", f, o_debug_state); end
         if (f >= 4) begin
            checks++; if (data !== 32'h9555_6AAA) begin errors++; $display("FAIL lock_data frame %0d got %h want 95556aaa", f, data); end
         end
      end
      #5;
      checks++; if (push_seen !== m_pushes) begin errors++; $display("FAIL lock_push_count got %0d want %0d", push_seen, m_pushes); end
   endtask

   task automatic test_fifo_full();
      logic push; logic [31:0] data;
      for (int f = 0; f < 4; f++) begin
         send_frame(13'($urandom), 13'($urandom), 1'($urandom), QSY, (f < 3), push, data);
         checks++; if (push !== m_push) begin errors++; $display("FAIL full_push frame %0d got %b want %b", f, push, m_push); end
         checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL full_locked frame %0d got %b want 1", f, o_locked); end
         checks++; if (data !== m_data) begin errors++; $display("FAIL full_data frame %0d got %h want %h", f, data, m_data); end
         checks++; if (o_ovf_cnt !== 2'(m_ovf)) begin errors++; $display("FAIL full_ovf frame %0d got %0d want %0d", f, o_ovf_cnt, m_ovf); end
      end
   endtask

   task automatic test_bad_q();
      logic push; logic [31:0] data;
      send_frame(13'($urandom), 13'($urandom), 1'b0, 2'b00, 1'b0, push, data);
      checks++; if (push !== 1'b0 || o_locked !== 1'b0) begin
         errors++; $display("FAIL badq_unlock got push %b locked %b want 0 0", push, o_locked); end
      checks++; if (o_debug_state !== 2'b00) begin errors++; $display("FAIL badq_state got %b want 00", o_debug_state); end
      checks++; if (o_sync_err_cnt !== 2'(m_err)) begin errors++; $display("FAIL badq_err got %0d want %0d", o_sync_err_cnt, m_err); end
      for (int f = 1; f <= 4; f++) begin
         send_frame(13'($urandom), 13'($urandom), 1'($urandom), QSY, 1'b0, push, data);
         checks++; if (push !== (f == 4)) begin errors++; $display("FAIL badq_relock frame %0d got %b want %b", f, push, f == 4); end
         checks++; if (data !== m_data) begin errors++; $display("FAIL badq_data frame %0d got %h want %h", f, data, m_data); end
      end
   endtask

   task automatic test_gap();
      logic push; logic [31:0] data;
      send_idle(2'b00, 1'b0);
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL gap_locked got %b want 0", o_locked); end
      checks++; if (o_sync_err_cnt !== 2'(m_err)) begin errors++; $display("FAIL gap_err got %0d want %0d", o_sync_err_cnt, m_err); end
      for (int f = 1; f <= 4; f++) begin
         send_frame(13'($urandom), 13'($urandom), 1'($urandom), QSY, 1'b0, push, data);
         checks++; if (push !== (f == 4)) begin errors++; $display("FAIL gap_relock frame %0d got %b want %b", f, push, f == 4); end
      end
      checks++; if (data !== m_data) begin errors++; $display("FAIL gap_data got %h want %h", data, m_data); end
   endtask

   task automatic test_sat_clear();
      logic push; logic [31:0] data;
      for (int e = 0; e < 5; e++) begin
         send_frame(13'($urandom), 13'($urandom), 1'($urandom), QSY, 1'b0, push, data);
         send_idle(idle_dibit(), 1'b0);
         checks++; if (o_sync_err_cnt !== 2'(m_err)) begin errors++; $display("FAIL sat_err step %0d got %0d want %0d", e, o_sync_err_cnt, m_err); end
      end
      send_frame(13'($urandom), 13'($urandom), 1'($urandom), QSY, 1'b0, push, data);
      send_idle(idle_dibit(), 1'b1);
      checks++; if (o_sync_err_cnt !== 2'd0) begin errors++; $display("FAIL clear_err got %0d want 0", o_sync_err_cnt); end
      checks++; if (o_ovf_cnt !== 2'(m_ovf)) begin errors++; $display("FAIL clear_ovf got %0d want %0d", o_ovf_cnt, m_ovf); end
   endtask

   task automatic test_random();
      logic push; logic [31:0] data; logic [1:0] qs;
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 6) == 0) send_idle(idle_dibit(), 1'b0);
         qs = ($urandom_range(0, 9) == 0) ? idle_dibit() ^ 2'b01 : QSY;
         if (qs == QSY) qs = ($urandom_range(0, 9) == 0) ? 2'b00 : QSY;
         send_frame(13'($urandom), 13'($urandom), 1'($urandom), qs, ($urandom_range(0, 3) == 0), push, data);
         checks++; if (push !== m_push) begin errors++; $display("FAIL rand_push frame %0d got %b want %b", f, push, m_push); end
         checks++; if (data !== m_data) begin errors++; $display("FAIL rand_data frame %0d got %h want %h", f, data, m_data); end
         checks++; if (o_locked !== m_locked) begin errors++; $display("FAIL rand_locked frame %0d got %b want %b", f, o_locked, m_locked); end
         checks++; if (o_sync_err_cnt !== 2'(m_err) || o_ovf_cnt !== 2'(m_ovf)) begin
            errors++; $display("FAIL rand_counters frame %0d got %0d/%0d want %0d/%0d", f, o_sync_err_cnt, o_ovf_cnt, m_err, m_ovf); end
      end
      #5;
      checks++; if (push_seen !== m_pushes) begin errors++; $display("FAIL rand_push_count got %0d want %0d", push_seen, m_pushes); end
   endtask

   task automatic test_reset_mid();
      logic push; logic [31:0] data; logic [12:0] iv, qv;
      for (int f = 0; f < 4; f++) send_frame(13'($urandom), 13'($urandom), 1'($urandom), QSY, 1'b0, push, data);
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL mid_prelock got %b want 1", o_locked); end
      i_sync_input = 1'b1;
      tick(ISY, 1'b0);
      for (int k = 0; k < 7; k++) tick(2'($urandom), 1'b0);
      tick(QSY, 1'b0);
      for (int k = 0; k < 3; k++) tick(2'($urandom), 1'b0);
      checks++; if (o_debug_state !== 2'b11) begin errors++; $display("FAIL mid_qph_state got %b want 11", o_debug_state); end
      #2 i_rst_b = 1'b0;
      #1;
      checks++; if (o_fifo_push !== 1'b0 || o_locked !== 1'b0) begin
         errors++; $display("FAIL mid_reset_out got push %b locked %b want 0 0", o_fifo_push, o_locked); end
      checks++; if (o_debug_state !== 2'b00) begin errors++; $display("FAIL mid_reset_state got %b want 00", o_debug_state); end
      model_reset();
      i_ddr_data = 2'b00;
      @(negedge i_ddr_clk); i_rst_b = 1'b1;
      for (int f = 1; f <= 4; f++) begin
         iv = 13'($urandom); qv = 13'($urandom);
         send_frame(iv, qv, 1'b0, QSY, 1'b0, push, data);
         checks++; if (push !== (f == 4)) begin errors++; $display("FAIL post_reset_push frame %0d got %b want %b", f, push, f == 4); end
         if (f == 4) begin
            checks++; if (data !== {ISY, iv, 1'b0, QSY, qv, 1'b0}) begin
               errors++; $display("FAIL post_reset_data got %h want %h", data, {ISY, iv, 1'b0, QSY, qv, 1'b0}); end
         end
      end
      #5;
      checks++; if (push_seen !== m_pushes) begin errors++; $display("FAIL total_push_count got %0d want %0d", push_seen, m_pushes); end
   endtask

   initial begin
      test_reset();
      test_lock_acq();
      test_fifo_full();
      test_bad_q();
      test_gap();
      test_sat_clear();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
